// File: rtl/l1d_refill_ctrl.sv
// l1d_refill_ctrl: L1 dcache miss handler; picks a fill way, writes back a dirty victim, refills and commits.
module l1d_refill_ctrl #(
  parameter int NUM_WAYS   = 4,
  parameter int ADDR_W     = 32,
  parameter int SETS       = 64,
  parameter int LINE_BYTES = 64,
  parameter int BUS_W      = 64,
  localparam int WAY_W  = $clog2(NUM_WAYS),
  localparam int SET_W  = $clog2(SETS),
  localparam int OFF_W  = $clog2(LINE_BYTES),
  localparam int TAG_W  = ADDR_W - SET_W - OFF_W,
  localparam int BEATS  = LINE_BYTES * 8 / BUS_W,
  localparam int BEAT_W = $clog2(BEATS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      miss_valid,
  output logic                      miss_ready,
  input  logic [ADDR_W-1:0]         miss_addr,
  input  logic [NUM_WAYS-1:0]       way_valid,
  input  logic [NUM_WAYS-1:0]       way_dirty,
  input  logic [NUM_WAYS*TAG_W-1:0] way_tags,
  input  logic [WAY_W-1:0]          plru_victim,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [ADDR_W-1:0]         wb_addr,
  output logic [BUS_W-1:0]          wb_data,
  output logic                      wb_last,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [ADDR_W-1:0]         mem_req_addr,
  input  logic                      mem_rsp_valid,
  input  logic [BUS_W-1:0]          mem_rsp_data,
  output logic                      dary_rd_en,
  input  logic [BUS_W-1:0]          dary_rd_data,
  output logic                      dary_wr_en,
  output logic [BUS_W-1:0]          dary_wr_data,
  output logic [WAY_W-1:0]          dary_way,
  output logic [SET_W-1:0]          dary_set,
  output logic [BEAT_W-1:0]         dary_beat,
  output logic                      tag_wr_en,
  output logic [TAG_W-1:0]          tag_wr_tag,
  output logic                      commit
);
  typedef enum logic [2:0] {IDLE, WB_RD, WB_DATA, RF_REQ, RF_DATA, COMMIT} state_t;
  state_t state, state_n;
  logic [BEAT_W-1:0] cnt;
  logic [WAY_W-1:0]  way_q, pick;
  logic [SET_W-1:0]  set_q;
  logic [TAG_W-1:0]  tag_q, vtag_q;
  logic [BUS_W-1:0]  data_q;
  logic              pick_dirty, last, accept, unused_ok;
  assign last      = cnt == BEAT_W'(BEATS - 1);
  assign accept    = state == IDLE && miss_valid;
  assign unused_ok = ^miss_addr[OFF_W-1:0];
  // Lowest-index invalid way wins; the PLRU victim is only used for a full set.
  always_comb begin
    pick = plru_victim;
    for (int i = NUM_WAYS - 1; i >= 0; i--)
      if (!way_valid[i]) pick = WAY_W'(i);
    pick_dirty = way_valid[pick] & way_dirty[pick];
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (miss_valid) state_n = pick_dirty ? WB_RD : RF_REQ;
      WB_RD:   state_n = WB_DATA;
      WB_DATA: if (wb_ready) state_n = last ? RF_REQ : WB_RD;
      RF_REQ:  if (mem_req_ready) state_n = RF_DATA;
      RF_DATA: if (mem_rsp_valid && last) state_n = COMMIT;
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      way_q  <= '0;
      set_q  <= '0;
      tag_q  <= '0;
      vtag_q <= '0;
      data_q <= '0;
    end else begin
      if (accept) begin
        set_q  <= miss_addr[OFF_W +: SET_W];
        tag_q  <= miss_addr[ADDR_W-1 -: TAG_W];
        way_q  <= pick;
        vtag_q <= way_tags[pick*TAG_W +: TAG_W];
        cnt    <= '0;
      end
      if (state == WB_RD) data_q <= dary_rd_data;
      if (state == WB_DATA && wb_ready) cnt <= last ? '0 : cnt + 1'b1;
      if (state == RF_DATA && mem_rsp_valid) cnt <= cnt + 1'b1;
    end
  end
  assign miss_ready    = state == IDLE;
  assign wb_valid      = state == WB_DATA;
  assign wb_addr       = {vtag_q, set_q, {OFF_W{1'b0}}};
  assign wb_data       = data_q;
  assign wb_last       = wb_valid && last;
  assign mem_req_valid = state == RF_REQ;
  assign mem_req_addr  = {tag_q, set_q, {OFF_W{1'b0}}};
  assign dary_rd_en    = state == WB_RD;
  assign dary_wr_en    = state == RF_DATA && mem_rsp_valid;
  assign dary_wr_data  = mem_rsp_data;
  assign dary_way      = way_q;
  assign dary_set      = set_q;
  assign dary_beat     = cnt;
  assign tag_wr_en     = state == COMMIT;
  assign tag_wr_tag    = tag_q;
  assign commit        = state == COMMIT;
endmodule

// File: tb/tb_l1d_refill_ctrl.sv
// tb_l1d_refill_ctrl: directed scenarios for the L1 dcache refill controller.
module tb_l1d_refill_ctrl;
  logic        clk = 0, rst_n = 0;
  logic        miss_valid = 0, miss_ready;
  logic [31:0] miss_addr = 0;
  logic [3:0]  way_valid = 0, way_dirty = 0;
  logic [79:0] way_tags = 0;
  logic [1:0]  plru_victim = 0;
  logic        wb_valid, wb_ready = 0, wb_last;
  logic [31:0] wb_addr, mem_req_addr;
  logic [63:0] wb_data, mem_rsp_data = 0, dary_rd_data, dary_wr_data;
  logic        mem_req_valid, mem_req_ready = 0, mem_rsp_valid = 0;
  logic        dary_rd_en, dary_wr_en, tag_wr_en, commit;
  logic [1:0]  dary_way;
  logic [5:0]  dary_set;
  logic [2:0]  dary_beat;
  logic [19:0] tag_wr_tag;
  always #5 clk = ~clk;
  l1d_refill_ctrl dut (
    .clk(clk), .rst_n(rst_n), .miss_valid(miss_valid), .miss_ready(miss_ready),
    .miss_addr(miss_addr), .way_valid(way_valid), .way_dirty(way_dirty),
    .way_tags(way_tags), .plru_victim(plru_victim), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data), .wb_last(wb_last),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .dary_rd_en(dary_rd_en), .dary_rd_data(dary_rd_data),
    .dary_wr_en(dary_wr_en), .dary_wr_data(dary_wr_data), .dary_way(dary_way),
    .dary_set(dary_set), .dary_beat(dary_beat), .tag_wr_en(tag_wr_en),
    .tag_wr_tag(tag_wr_tag), .commit(commit)
  );
  // Data array model: read data follows the addressed way/beat and is held while the beat index is.
  logic [63:0] arr [4][8];
  assign dary_rd_data = arr[dary_way][dary_beat];
  int tests = 0, fails = 0, seq = 0;
  int n_wb, n_rd, n_wr, n_commit, n_tagwr, commit_k, last_wr_k, req_k;
  logic [31:0] req_addr, wb_addr0;
  logic [1:0]  commit_way;
  logic [5:0]  commit_set;
  logic [19:0] commit_tag;
  logic        wb_ok, wr_ok, stable_ok, acc_ready;
  function automatic logic [63:0] rsp_pat(int i);
    return 64'hF111_0000_0000_0000 | (64'(seq) << 16) | 64'(i);
  endfunction
  task automatic do_miss(input logic [31:0] addr, input logic [3:0] v, input logic [3:0] d,
                         input logic [79:0] tags, input logic [1:0] vic, input logic [1:0] xw,
                         input int stall_beat, input bit gaps, input bit stray, input int abort_at);
    int stall, rf_k, n_sent;
    bit rf, done, stray_done;
    logic [63:0] hold;
    stall = 0; rf_k = 0; n_sent = 0; rf = 0; done = 0; stray_done = 0; hold = '0;
    n_wb = 0; n_rd = 0; n_wr = 0; n_commit = 0; n_tagwr = 0;
    commit_k = -1; last_wr_k = -1; req_k = -1; req_addr = 'x; wb_addr0 = 'x;
    commit_way = 'x; commit_set = 'x; commit_tag = 'x;
    wb_ok = 1; wr_ok = 1; stable_ok = 1;
    seq++;
    @(negedge clk);
    acc_ready = miss_ready;
    miss_valid = 1; miss_addr = addr; way_valid = v; way_dirty = d; way_tags = tags; plru_victim = vic;
    for (int k = 1; k <= 200 && !done; k++) begin
      @(negedge clk);
      miss_valid = 0; wb_ready = 0; mem_req_ready = 0; mem_rsp_valid = 0;
      if (dary_rd_en) n_rd++;
      if (wb_valid) begin
        if (n_wb == 0 && stall == 0) wb_addr0 = wb_addr;
        else if (wb_addr !== wb_addr0) stable_ok = 0;
        if (n_wb == stall_beat && stall < 5) begin
          if (stall == 0) hold = wb_data;
          else if (wb_data !== hold) stable_ok = 0;
          stall++;
        end else begin
          if (n_wb == stall_beat && wb_data !== hold) stable_ok = 0;
          wb_ready = 1;
          if (wb_data !== arr[xw][n_wb] || wb_last !== (n_wb == 7)) wb_ok = 0;
          n_wb++;
        end
      end
      if (rf && n_sent < 8 && (!gaps || rf_k % 2 == 0)) begin
        mem_rsp_valid = 1; mem_rsp_data = rsp_pat(n_sent); n_sent++;
      end
      if (rf) rf_k++;
      if (mem_req_valid) begin
        if (stray && !stray_done) begin
          mem_rsp_valid = 1; mem_rsp_data = 64'hBAD0_BAD0_BAD0_BAD0; stray_done = 1;
        end else begin
          mem_req_ready = 1; req_k = k; req_addr = mem_req_addr; rf = 1;
        end
      end
      #1;
      if (dary_wr_en) begin
        if (dary_wr_data !== rsp_pat(n_wr) || dary_beat !== 3'(n_wr) || dary_way !== xw) wr_ok = 0;
        n_wr++; last_wr_k = k;
      end
      if (tag_wr_en) n_tagwr++;
      if (commit) begin
        n_commit++; commit_k = k; commit_way = dary_way; commit_set = dary_set;
        commit_tag = tag_wr_tag; done = 1;
      end
      if (abort_at > 0 && n_wr == abort_at) begin rst_n = 0; done = 1; end
    end
    wb_ready = 0; mem_req_ready = 0; mem_rsp_valid = 0;
  endtask
  task automatic test_reset;
    logic [5:0] en;
    rst_n = 0;
    repeat (2) @(negedge clk);
    en = {commit, tag_wr_en, wb_valid, mem_req_valid, dary_rd_en, dary_wr_en};
    tests++; if (en !== 6'b0) begin fails++; $display("FAIL reset_enables: got %b exp 000000", en); end
    rst_n = 1;
    @(negedge clk);
    tests++; if (miss_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b exp 1", miss_ready); end
    tests++; if ({dary_way, dary_set, dary_beat} !== 11'b0) begin fails++; $display("FAIL reset_latched: got %h exp 0", {dary_way, dary_set, dary_beat}); end
  endtask
  task automatic test_cold;
    do_miss(32'h0000_1240, 4'b0000, 4'b0000, {4{20'hCCCCC}}, 2'd2, 2'd0, -1, 0, 0, 0);
    tests++; if (acc_ready !== 1'b1) begin fails++; $display("FAIL cold_ready: got %b exp 1", acc_ready); end
    tests++; if (n_wb !== 0 || n_rd !== 0) begin fails++; $display("FAIL cold_nowb: got wb=%0d rd=%0d exp 0/0", n_wb, n_rd); end
    tests++; if (req_addr !== 32'h0000_1240) begin fails++; $display("FAIL cold_req_addr: got %h exp 00001240", req_addr); end
    tests++; if (req_k !== 1) begin fails++; $display("FAIL cold_req_cycle: got %0d exp 1", req_k); end
    tests++; if (n_wr !== 8 || !wr_ok) begin fails++; $display("FAIL cold_writes: got n=%0d ok=%b exp 8/1", n_wr, wr_ok); end
    tests++; if (commit_tag !== 20'h1) begin fails++; $display("FAIL cold_tag: got %h exp 00001", commit_tag); end
    tests++; if (n_commit !== 1 || n_tagwr !== 1) begin fails++; $display("FAIL cold_commit_cnt: got %0d/%0d exp 1/1", n_commit, n_tagwr); end
    tests++; if (commit_k !== 10) begin fails++; $display("FAIL cold_latency: got %0d exp 10", commit_k); end
    tests++; if ({commit_way, commit_set} !== {2'd0, 6'd9}) begin fails++; $display("FAIL cold_way_set: got %0d/%0d exp 0/9", commit_way, commit_set); end
  endtask
  task automatic test_full_clean;
    do_miss(32'h0002_3F80, 4'hF, 4'h0, {4{20'h12345}}, 2'd3, 2'd3, -1, 0, 0, 0);
    tests++; if (acc_ready !== 1'b1) begin fails++; $display("FAIL clean_ready: got %b exp 1", acc_ready); end
    tests++; if (n_wb !== 0 || n_rd !== 0) begin fails++; $display("FAIL clean_nowb: got wb=%0d rd=%0d exp 0/0", n_wb, n_rd); end
    tests++; if (commit_way !== 2'd3) begin fails++; $display("FAIL clean_way: got %0d exp 3", commit_way); end
    tests++; if (commit_tag !== 20'h23 || req_addr !== 32'h0002_3F80) begin fails++; $display("FAIL clean_addr: got tag=%h req=%h exp 00023/00023f80", commit_tag, req_addr); end
    tests++; if (n_wr !== 8 || !wr_ok || commit_k !== 10) begin fails++; $display("FAIL clean_refill: got n=%0d ok=%b k=%0d exp 8/1/10", n_wr, wr_ok, commit_k); end
  endtask
  task automatic test_dirty;
    do_miss(32'h0000_7240, 4'hF, 4'b0010, {20'hAAAA3, 20'hAAAA2, 20'h00005, 20'hAAAA0}, 2'd1, 2'd1, -1, 0, 0, 0);
    tests++; if (n_wb !== 8 || !wb_ok) begin fails++; $display("FAIL dirty_wb: got n=%0d ok=%b exp 8/1", n_wb, wb_ok); end
    tests++; if (wb_addr0 !== 32'h0000_5240 || !stable_ok) begin fails++; $display("FAIL dirty_wb_addr: got %h stable=%b exp 00005240/1", wb_addr0, stable_ok); end
    tests++; if (n_rd !== 8) begin fails++; $display("FAIL dirty_rd: got %0d exp 8", n_rd); end
    tests++; if (req_addr !== 32'h0000_7240 || commit_tag !== 20'h7) begin fails++; $display("FAIL dirty_req: got %h tag=%h exp 00007240/00007", req_addr, commit_tag); end
    tests++; if (n_wr !== 8 || !wr_ok || commit_way !== 2'd1) begin fails++; $display("FAIL dirty_refill: got n=%0d ok=%b way=%0d exp 8/1/1", n_wr, wr_ok, commit_way); end
    tests++; if (commit_k !== 26) begin fails++; $display("FAIL dirty_latency: got %0d exp 26", commit_k); end
  endtask
  task automatic test_backpressure;
    do_miss(32'hABCD_E400, 4'hF, 4'b0100, {20'h11111, 20'h00003, 20'h22222, 20'h33333}, 2'd2, 2'd2, 3, 0, 0, 0);
    tests++; if (n_wb !== 8 || !wb_ok) begin fails++; $display("FAIL bp_order: got n=%0d ok=%b exp 8/1", n_wb, wb_ok); end
    tests++; if (!stable_ok || wb_addr0 !== 32'h0000_3400) begin fails++; $display("FAIL bp_stable: got stable=%b addr=%h exp 1/00003400", stable_ok, wb_addr0); end
    tests++; if (n_rd !== 8) begin fails++; $display("FAIL bp_rd: got %0d exp 8", n_rd); end
    tests++; if (commit_k !== 31 || commit_tag !== 20'hABCDE) begin fails++; $display("FAIL bp_commit: got k=%0d tag=%h exp 31/abcde", commit_k, commit_tag); end
  endtask
  task automatic test_refill_gaps;
    do_miss(32'h0000_0FC0, 4'b1011, 4'hF, {4{20'h0FFFF}}, 2'd0, 2'd2, -1, 1, 1, 0);
    tests++; if (acc_ready !== 1'b1) begin fails++; $display("FAIL gaps_b2b_ready: got %b exp 1", acc_ready); end
    tests++; if (n_wb !== 0 || commit_way !== 2'd2) begin fails++; $display("FAIL gaps_invalid_first: got wb=%0d way=%0d exp 0/2", n_wb, commit_way); end
    tests++; if (n_wr !== 8 || !wr_ok) begin fails++; $display("FAIL gaps_writes: got n=%0d ok=%b exp 8/1", n_wr, wr_ok); end
    tests++; if (req_k !== 2 || last_wr_k !== 17) begin fails++; $display("FAIL gaps_timing: got req=%0d last=%0d exp 2/17", req_k, last_wr_k); end
    tests++; if (commit_k !== 18 || commit_set !== 6'h3F || commit_tag !== 20'h0) begin fails++; $display("FAIL gaps_commit: got k=%0d set=%h tag=%h exp 18/3f/00000", commit_k, commit_set, commit_tag); end
  endtask
  task automatic test_reset_mid;
    logic seen;
    seen = 0;
    do_miss(32'h0001_2340, 4'hF, 4'h0, {4{20'h00777}}, 2'd0, 2'd0, -1, 0, 0, 3);
    tests++; if (n_wr !== 3 || n_commit !== 0 || n_tagwr !== 0) begin fails++; $display("FAIL abort_pre: got wr=%0d c=%0d t=%0d exp 3/0/0", n_wr, n_commit, n_tagwr); end
    #1;
    tests++; if ({dary_way, dary_set, dary_beat, dary_wr_en, mem_req_valid} !== 13'b0) begin fails++; $display("FAIL abort_cleared: got %h exp 0", {dary_way, dary_set, dary_beat, dary_wr_en, mem_req_valid}); end
    repeat (2) begin @(negedge clk); if (commit || tag_wr_en) seen = 1; end
    rst_n = 1;
    @(negedge clk);
    if (commit || tag_wr_en) seen = 1;
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL abort_no_commit: got %b exp 0", seen); end
    tests++; if (miss_ready !== 1'b1) begin fails++; $display("FAIL abort_ready: got %b exp 1", miss_ready); end
    do_miss(32'h0001_2340, 4'hF, 4'h0, {4{20'h00777}}, 2'd0, 2'd0, -1, 0, 0, 0);
    tests++; if (n_wr !== 8 || !wr_ok || n_commit !== 1 || commit_k !== 10) begin fails++; $display("FAIL abort_retry: got wr=%0d ok=%b c=%0d k=%0d exp 8/1/1/10", n_wr, wr_ok, n_commit, commit_k); end
    tests++; if (commit_tag !== 20'h12 || commit_set !== 6'h0D) begin fails++; $display("FAIL abort_retry_tag: got %h/%h exp 00012/0d", commit_tag, commit_set); end
  endtask
  initial begin
    for (int w = 0; w < 4; w++)
      for (int b = 0; b < 8; b++)
        arr[w][b] = 64'hDA7A_0000_0000_0000 | (64'(w) << 32) | (64'(b) << 4) | 64'(w + b);
    test_reset;
    test_cold;
    test_full_clean;
    test_dirty;
    test_backpressure;
    test_refill_gaps;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
